// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    // MDU operation select carried in the ID/EX register
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    // Iteration FSM state codes
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    // EX result-mux selects for mfhi/mflo
    localparam int unsigned ALU_SEL_W = 5;
    localparam logic [ALU_SEL_W-1:0] ALU_MFHI = 5'h1E;
    localparam logic [ALU_SEL_W-1:0] ALU_MFLO = 5'h1F;

    // Per-operation context captured at launch and consumed at FIX
    typedef struct packed {
        logic mult;   // 1: multiply, 0: divide
        logic qneg;   // negate product (MULT) or quotient (DIV) on exit
        logic rneg;   // negate remainder on exit (DIV only)
    } mdu_ctx_t;

    function automatic logic mdu_is_div(mdu_op_e op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(mdu_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bus between ID/EX, hazard control and the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = ex_muldiv_unit_pkg::MDU_WIDTH
);
    import ex_muldiv_unit_pkg::*;

    logic             StartIn;
    mdu_op_e          MDUOpIn;
    logic [WIDTH-1:0] AIn;
    logic [WIDTH-1:0] BIn;
    logic             HIWrIn;
    logic             LOWrIn;
    logic             FlushIn;
    logic             BusyOut;
    logic             DoneOut;
    logic [WIDTH-1:0] HIOut;
    logic [WIDTH-1:0] LOOut;

    // Pipeline / hazard-control side
    modport master (
        output StartIn, MDUOpIn, AIn, BIn, HIWrIn, LOWrIn, FlushIn,
        input  BusyOut, DoneOut, HIOut, LOOut
    );

    // Multiply/divide unit side
    modport slave (
        input  StartIn, MDUOpIn, AIn, BIn, HIWrIn, LOWrIn, FlushIn,
        output BusyOut, DoneOut, HIOut, LOOut
    );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: abs-value on operand entry, sign restore on result exit.
module mdu_sign_fix #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] val_o
);

    // Negate when requested, pass through otherwise
    assign val_o = neg_i ? (N'(0) - val_i) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding architectural HI/LO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   mdu
);

    localparam int unsigned W     = WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mdu_ctx_t         ctx_q, ctx_d;
    logic [W:0]       opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [W-1:0]     rem_q, rem_d;       // product high half / partial remainder
    logic [W-1:0]     quo_q, quo_d;       // multiplier->product low half / dividend->quotient
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             done_q, done_d;

    // Launch-time operand decode
    logic       op_signed, op_div, a_neg, b_neg, b_zero;
    logic [W:0] a_mag, b_mag;

    assign op_signed = mdu_is_signed(mdu.MDUOpIn);
    assign op_div    = mdu_is_div(mdu.MDUOpIn);
    assign a_neg     = op_signed & mdu.AIn[W-1];
    assign b_neg     = op_signed & mdu.BIn[W-1];
    assign b_zero    = (mdu.BIn == '0);

    // W+1-bit magnitudes keep |most-negative| exact
    mdu_sign_fix #(.N(W+1)) u_abs_a (
        .val_i ({a_neg, mdu.AIn}),
        .neg_i (a_neg),
        .val_o (a_mag)
    );

    mdu_sign_fix #(.N(W+1)) u_abs_b (
        .val_i ({b_neg, mdu.BIn}),
        .neg_i (b_neg),
        .val_o (b_mag)
    );

    // One radix-2 iteration of each algorithm
    logic [W:0]   mul_sum;
    logic [W:0]   div_shift;
    logic         div_borrow;
    logic [W-1:0] div_rem;

    assign mul_sum    = {1'b0, rem_q} + (quo_q[0] ? opnd_q : '0);
    assign div_shift  = {rem_q, quo_q[W-1]};
    assign div_borrow = (div_shift < opnd_q);
    assign div_rem    = div_borrow ? div_shift[W-1:0] : W'(div_shift - opnd_q);

    // Sign restoration of the finished result
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    mdu_sign_fix #(.N(2*W)) u_fix_prod (
        .val_i ({rem_q, quo_q}),
        .neg_i (ctx_q.qneg),
        .val_o (prod_fix)
    );

    mdu_sign_fix #(.N(W)) u_fix_quo (
        .val_i (quo_q),
        .neg_i (ctx_q.qneg),
        .val_o (quo_fix)
    );

    mdu_sign_fix #(.N(W)) u_fix_rem (
        .val_i (rem_q),
        .neg_i (ctx_q.rneg),
        .val_o (rem_fix)
    );

    // Next-state, datapath iteration and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctx_d   = ctx_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (mdu.HIWrIn) hi_d = mdu.AIn;
                if (mdu.LOWrIn) lo_d = mdu.AIn;
                if (mdu.StartIn && !mdu.FlushIn) begin
                    state_d    = MDU_RUN;
                    cnt_d      = '0;
                    ctx_d.mult = ~op_div;
                    // A zero divisor keeps the all-ones quotient unsigned
                    ctx_d.qneg = (a_neg ^ b_neg) & ~(op_div & b_zero);
                    ctx_d.rneg = a_neg;
                    opnd_d     = op_div ? b_mag : a_mag;
                    rem_d      = '0;
                    quo_d      = op_div ? a_mag[W-1:0] : b_mag[W-1:0];
                end
            end
            MDU_RUN: begin
                if (mdu.FlushIn) begin
                    state_d = MDU_IDLE;
                end else begin
                    if (ctx_q.mult) begin
                        rem_d = mul_sum[W:1];
                        quo_d = {mul_sum[0], quo_q[W-1:1]};
                    end else begin
                        rem_d = div_rem;
                        quo_d = {quo_q[W-2:0], ~div_borrow};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W-1)) state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                state_d = MDU_IDLE;
                if (!mdu.FlushIn) begin
                    done_d = 1'b1;
                    if (ctx_q.mult) begin
                        hi_d = prod_fix[2*W-1:W];
                        lo_d = prod_fix[W-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            ctx_q   <= '0;
            opnd_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctx_q   <= ctx_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign mdu.BusyOut = (state_q == MDU_RUN) || (state_q == MDU_FIX);
    assign mdu.DoneOut = done_q;
    assign mdu.HIOut   = hi_q;
    assign mdu.LOOut   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed cases, flush/reset corners, random ops.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    localparam int unsigned W   = 32;
    localparam int          LAT = 34;
    localparam int          TMO = 60;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   checks;
    int   errors;

    ex_muldiv_unit_if #(.WIDTH(W)) bus();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model built on 64-bit SV arithmetic
    function automatic exp_t model(mdu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, sp, sq, sr;
        logic [2*W-1:0]        ua, ub, up, uq, ur;
        exp_t                  r;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        r  = '0;
        case (op)
            MDU_MULT: begin
                sp = sa * sb;
                r.hi = sp[2*W-1:W]; r.lo = sp[W-1:0];
            end
            MDU_MULTU: begin
                up = ua * ub;
                r.hi = up[2*W-1:W]; r.lo = up[W-1:0];
            end
            MDU_DIV: begin
                if (b == '0) begin
                    r.hi = a; r.lo = {W{1'b1}};
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    r.hi = sr[W-1:0]; r.lo = sq[W-1:0];
                end
            end
            default: begin
                if (b == '0) begin
                    r.hi = a; r.lo = {W{1'b1}};
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    r.hi = ur[W-1:0]; r.lo = uq[W-1:0];
                end
            end
        endcase
        return r;
    endfunction

    // Drive StartIn for one cycle; returns one cycle later (cycle T+1)
    task automatic launch(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic push, input exp_t exp);
        bus.StartIn = 1'b1;
        bus.MDUOpIn = op;
        bus.AIn     = a;
        bus.BIn     = b;
        if (push) sb_q.push_back(exp);
        tick();
        bus.StartIn = 1'b0;
    endtask

    // Wait (bounded) for DoneOut; report latency, busy cycles, result and scoreboard entry
    task automatic collect(output int done_at, output int busy_n, output exp_t got, output exp_t exp);
        done_at = 0;
        busy_n  = 0;
        got     = '0;
        exp     = 'x;
        for (int k = 1; k <= TMO; k++) begin
            if (bus.DoneOut === 1'b1) begin
                done_at = k;
                got     = {bus.HIOut, bus.LOOut};
                break;
            end
            busy_n += int'(bus.BusyOut);
            tick();
        end
        if (sb_q.size() > 0) exp = sb_q.pop_front();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (bus.BusyOut !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BusyOut); end
        checks++; if (bus.DoneOut !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.DoneOut); end
        checks++; if (bus.HIOut !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.HIOut); end
        checks++; if (bus.LOOut !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.LOOut); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int d, b; exp_t got, exp;
        launch(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        collect(d, b, got, exp);
        checks++; if (d !== LAT) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", d, LAT); end
        checks++; if (b !== LAT - 1) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected %0d", b, LAT - 1); end
        checks++; if (got !== exp) begin errors++; $display("FAIL mult_result: got %h expected %h", got, exp); end
        tick();
        checks++; if (bus.DoneOut !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", bus.DoneOut); end
    endtask

    task automatic test_multu();
        int d, b; exp_t got, exp;
        launch(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, {32'h0000_0001, 32'hFFFF_FFFE});
        collect(d, b, got, exp);
        checks++; if (d !== LAT) begin errors++; $display("FAIL multu_latency: got %0d expected %0d", d, LAT); end
        checks++; if (got !== exp) begin errors++; $display("FAIL multu_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_div();
        logic [W-1:0] ta[2] = '{32'hFFFF_FFF9, 32'h8000_0000};
        logic [W-1:0] tb[2] = '{32'h0000_0002, 32'hFFFF_FFFF};
        exp_t         te[2] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0000, 32'h8000_0000}};
        int d, b; exp_t got, exp;
        for (int i = 0; i < 2; i++) begin
            launch(MDU_DIV, ta[i], tb[i], 1'b1, te[i]);
            collect(d, b, got, exp);
            checks++; if (d !== LAT) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, d, LAT); end
            checks++; if (got !== exp) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_divu();
        logic [W-1:0] ta[2] = '{32'd100, 32'h0000_1234};
        logic [W-1:0] tb[2] = '{32'd7, 32'd0};
        exp_t         te[2] = '{{32'h0000_0002, 32'h0000_000E}, {32'h0000_1234, 32'hFFFF_FFFF}};
        int d, b; exp_t got, exp;
        for (int i = 0; i < 2; i++) begin
            launch(MDU_DIVU, ta[i], tb[i], 1'b1, te[i]);
            collect(d, b, got, exp);
            checks++; if (d !== LAT) begin errors++; $display("FAIL divu_latency[%0d]: got %0d expected %0d", i, d, LAT); end
            checks++; if (got !== exp) begin errors++; $display("FAIL divu_result[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_flush();
        int pulses;
        bus.HIWrIn = 1'b1; bus.LOWrIn = 1'b1; bus.AIn = 32'h0000_5555;
        tick();
        bus.HIWrIn = 1'b0; bus.LOWrIn = 1'b0;
        checks++; if ({bus.HIOut, bus.LOOut} !== {32'h5555, 32'h5555}) begin errors++; $display("FAIL mthi_mtlo_both: got %h/%h expected 5555/5555", bus.HIOut, bus.LOOut); end
        bus.LOWrIn = 1'b1; bus.AIn = 32'h0000_AAAA;
        tick();
        bus.LOWrIn = 1'b0;
        checks++; if (bus.LOOut !== 32'hAAAA) begin errors++; $display("FAIL mtlo: got %h expected aaaa", bus.LOOut); end
        launch(MDU_MULT, 32'd3, 32'd4, 1'b0, '0);
        repeat (9) tick();
        checks++; if (bus.BusyOut !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b expected 1", bus.BusyOut); end
        bus.FlushIn = 1'b1;
        tick();
        bus.FlushIn = 1'b0;
        checks++; if (bus.BusyOut !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.BusyOut); end
        checks++; if (bus.LOOut !== 32'hAAAA) begin errors++; $display("FAIL flush_lo: got %h expected aaaa", bus.LOOut); end
        checks++; if (bus.HIOut !== 32'h5555) begin errors++; $display("FAIL flush_hi: got %h expected 5555", bus.HIOut); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            pulses += int'(bus.DoneOut);
            tick();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_start_flush();
        int act;
        bus.StartIn = 1'b1; bus.FlushIn = 1'b1; bus.MDUOpIn = MDU_MULT;
        bus.AIn = 32'd5; bus.BIn = 32'd6;
        tick();
        bus.StartIn = 1'b0; bus.FlushIn = 1'b0;
        act = 0;
        for (int k = 0; k < 40; k++) begin
            act += int'(bus.BusyOut) + int'(bus.DoneOut);
            tick();
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL start_flush_idle: got %0d active cycles expected 0", act); end
        checks++; if (bus.LOOut !== 32'hAAAA) begin errors++; $display("FAIL start_flush_lo: got %h expected aaaa", bus.LOOut); end
    endtask

    task automatic test_wr_with_start();
        int d, b; exp_t got, exp;
        bus.HIWrIn = 1'b1; bus.LOWrIn = 1'b1;
        launch(MDU_MULTU, 32'h77, 32'd3, 1'b1, {32'h0, 32'h165});
        bus.HIWrIn = 1'b0; bus.LOWrIn = 1'b0;
        checks++; if ({bus.HIOut, bus.LOOut} !== {32'h77, 32'h77}) begin errors++; $display("FAIL wr_with_start: got %h/%h expected 77/77", bus.HIOut, bus.LOOut); end
        collect(d, b, got, exp);
        checks++; if (got !== exp) begin errors++; $display("FAIL wr_then_op_result: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        int d, b; exp_t got, exp;
        launch(MDU_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        collect(d, b, got, exp);
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, exp); end
        launch(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        checks++; if (bus.BusyOut !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", bus.BusyOut); end
        collect(d, b, got, exp);
        checks++; if (d !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", d, LAT); end
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_second: got %h expected %h", got, exp); end
    endtask

    task automatic test_random();
        int d, b; exp_t got, exp;
        mdu_op_e op; logic [W-1:0] a, bv;
        for (int i = 0; i < 16; i++) begin
            op = mdu_op_e'($urandom_range(0, 3));
            a  = W'($urandom());
            bv = (i % 5 == 0) ? '0 : W'($urandom());
            if (i == 7) bv = W'($urandom_range(1, 9));
            launch(op, a, bv, 1'b1, model(op, a, bv));
            collect(d, b, got, exp);
            checks++; if (got !== exp || d !== LAT) begin errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h at %0d expected %h at %0d", i, op, a, bv, got, d, exp, LAT); end
        end
    endtask

    task automatic test_reset_mid();
        launch(MDU_DIVU, 32'd1000, 32'd9, 1'b0, '0);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.BusyOut !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.BusyOut); end
        checks++; if (bus.DoneOut !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", bus.DoneOut); end
        checks++; if ({bus.HIOut, bus.LOOut} !== '0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", bus.HIOut, bus.LOOut); end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.BusyOut !== 1'b0) begin errors++; $display("FAIL rst_mid_stays_idle: got %b expected 0", bus.BusyOut); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        checks = 0; errors = 0;
        bus.StartIn = 1'b0; bus.MDUOpIn = MDU_MULT; bus.AIn = '0; bus.BIn = '0;
        bus.HIWrIn = 1'b0; bus.LOWrIn = 1'b0; bus.FlushIn = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_flush();
        test_start_flush();
        test_wr_with_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
